// File: rtl/id_ex_stage_if.sv
// Decode-to-execute pipeline bus: D-stage instruction fields in, registered E-stage fields
// and load-use stall requests out.
interface id_ex_stage_if;
  logic        validd;
  logic        regwrited;
  logic        memtoregd;
  logic        memwrited;
  logic        alusrcd;
  logic        regdstd;
  logic        branchd;
  logic [2:0]  alucontrold;
  logic [31:0] rd1d;
  logic [31:0] rd2d;
  logic [31:0] signimmd;
  logic [31:0] pcplus4d;
  logic [4:0]  rsd;
  logic [4:0]  rtd;
  logic [4:0]  rdd;
  logic        flushe;

  logic        valide;
  logic        regwritee;
  logic        memtoregee;
  logic        memwritee;
  logic        alusrce;
  logic        regdste;
  logic        branche;
  logic [2:0]  alucontrole;
  logic [31:0] rd1e;
  logic [31:0] rd2e;
  logic [31:0] signimme;
  logic [31:0] pcplus4e;
  logic [4:0]  rse;
  logic [4:0]  rte;
  logic [4:0]  rde;
  logic        stallf;
  logic        stalld;
  logic [15:0] stallcnt;

  modport slave (
    input  validd, regwrited, memtoregd, memwrited, alusrcd, regdstd, branchd,
           alucontrold, rd1d, rd2d, signimmd, pcplus4d, rsd, rtd, rdd, flushe,
    output valide, regwritee, memtoregee, memwritee, alusrce, regdste, branche,
           alucontrole, rd1e, rd2e, signimme, pcplus4e, rse, rte, rde,
           stallf, stalld, stallcnt
  );

  modport master (
    output validd, regwrited, memtoregd, memwrited, alusrcd, regdstd, branchd,
           alucontrold, rd1d, rd2d, signimmd, pcplus4d, rsd, rtd, rdd, flushe,
    input  valide, regwritee, memtoregee, memwritee, alusrce, regdste, branche,
           alucontrole, rd1e, rd2e, signimme, pcplus4e, rse, rte, rde,
           stallf, stalld, stallcnt
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and a saturating stall counter.
// A bubble (all zeros) is loaded on stall, flush, or an invalid decode slot.
module id_ex_stage (
  input  logic       clk,
  input  logic       reset_n,
  id_ex_stage_if.slave bus
);

  function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
    return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  endfunction

  logic lwstall;
  logic take_p0;

  // A load in E whose destination feeds the D instruction must hold D one cycle.
  assign lwstall = bus.valide & bus.memtoregee & bus.validd & (bus.rte != 5'd0) &
                   ((bus.rte == bus.rsd) | (bus.rte == bus.rtd));
  assign bus.stallf = lwstall;
  assign bus.stalld = lwstall;

  // Gating data on take_p0 keeps X inputs from an invalid D slot out of E.
  assign take_p0 = bus.validd & ~lwstall & ~bus.flushe;

  // E stage register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.valide      <= 1'b0;
      bus.regwritee   <= 1'b0;
      bus.memtoregee  <= 1'b0;
      bus.memwritee   <= 1'b0;
      bus.alusrce     <= 1'b0;
      bus.regdste     <= 1'b0;
      bus.branche     <= 1'b0;
      bus.alucontrole <= 3'd0;
      bus.rd1e        <= 32'd0;
      bus.rd2e        <= 32'd0;
      bus.signimme    <= 32'd0;
      bus.pcplus4e    <= 32'd0;
      bus.rse         <= 5'd0;
      bus.rte         <= 5'd0;
      bus.rde         <= 5'd0;
      bus.stallcnt    <= 16'd0;
    end else begin
      bus.valide      <= take_p0;
      bus.regwritee   <= take_p0 & bus.regwrited;
      bus.memtoregee  <= take_p0 & bus.memtoregd;
      bus.memwritee   <= take_p0 & bus.memwrited;
      bus.alusrce     <= take_p0 & bus.alusrcd;
      bus.regdste     <= take_p0 & bus.regdstd;
      bus.branche     <= take_p0 & bus.branchd;
      bus.alucontrole <= take_p0 ? bus.alucontrold : 3'd0;
      bus.rd1e        <= take_p0 ? bus.rd1d        : 32'd0;
      bus.rd2e        <= take_p0 ? bus.rd2d        : 32'd0;
      bus.signimme    <= take_p0 ? bus.signimmd    : 32'd0;
      bus.pcplus4e    <= take_p0 ? bus.pcplus4d    : 32'd0;
      bus.rse         <= take_p0 ? bus.rsd         : 5'd0;
      bus.rte         <= take_p0 ? bus.rtd         : 5'd0;
      bus.rde         <= take_p0 ? bus.rdd         : 5'd0;
      bus.stallcnt    <= lwstall ? sat_inc(bus.stallcnt) : bus.stallcnt;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: expected E-stage contents are queued when an instruction
// is driven in D and compared after the capturing clock edge.
module tb_id_ex_stage;

  typedef struct packed {
    logic        valid;
    logic        rw;
    logic        mtr;
    logic        mw;
    logic        as;
    logic        rd;
    logic        br;
    logic [2:0]  alu;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc4;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rdd;
  } e_t;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;
  e_t   sb[$];
  e_t   model_e;
  logic [15:0] model_cnt;

  id_ex_stage_if ifc ();

  id_ex_stage dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic e_t mk(input logic v, rw, mtr, mw, as, rd, br, input logic [2:0] alu,
                            input logic [31:0] rd1, rd2, imm, pc4,
                            input logic [4:0] rs, rt, rdd);
    e_t d;
    d = '{v, rw, mtr, mw, as, rd, br, alu, rd1, rd2, imm, pc4, rs, rt, rdd};
    return d;
  endfunction

  function automatic e_t get_e();
    e_t e;
    e = '{ifc.valide, ifc.regwritee, ifc.memtoregee, ifc.memwritee, ifc.alusrce,
          ifc.regdste, ifc.branche, ifc.alucontrole, ifc.rd1e, ifc.rd2e, ifc.signimme,
          ifc.pcplus4e, ifc.rse, ifc.rte, ifc.rde};
    return e;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_d(input e_t d, input logic fl);
    ifc.validd      = d.valid;
    ifc.regwrited   = d.rw;
    ifc.memtoregd   = d.mtr;
    ifc.memwrited   = d.mw;
    ifc.alusrcd     = d.as;
    ifc.regdstd     = d.rd;
    ifc.branchd     = d.br;
    ifc.alucontrold = d.alu;
    ifc.rd1d        = d.rd1;
    ifc.rd2d        = d.rd2;
    ifc.signimmd    = d.imm;
    ifc.pcplus4d    = d.pc4;
    ifc.rsd         = d.rs;
    ifc.rtd         = d.rt;
    ifc.rdd         = d.rdd;
    ifc.flushe      = fl;
  endtask

  // Drive D at the negedge, check combinational stall, then check E after the posedge.
  task automatic apply(input e_t d, input logic fl, input string tag);
    logic exp_stall;
    e_t   nxt;
    e_t   exp;
    set_d(d, fl);
    #1;
    exp_stall = model_e.valid & model_e.mtr & d.valid & (model_e.rt != 5'd0) &
                ((model_e.rt == d.rs) | (model_e.rt == d.rt));
    chk({tag, ".stallf"}, 256'(ifc.stallf), 256'(exp_stall));
    chk({tag, ".stalld"}, 256'(ifc.stalld), 256'(exp_stall));
    nxt = (d.valid === 1'b1 && exp_stall === 1'b0 && fl === 1'b0) ? d : '0;
    sb.push_back(nxt);
    model_e = nxt;
    if (exp_stall && model_cnt != 16'hFFFF) model_cnt++;
    @(posedge clk);
    #1;
    exp = sb.pop_front();
    chk({tag, ".e"}, 256'(get_e()), 256'(exp));
    chk({tag, ".stallcnt"}, 256'(ifc.stallcnt), 256'(model_cnt));
    @(negedge clk);
  endtask

  initial begin
    e_t nop, add, lw8, dep8, lw0, dep0, lw9, dep9, sw, inv, lw6, dep6, lw7, dep7, r;
    checks    = 0;
    errors    = 0;
    model_e   = '0;
    model_cnt = 16'd0;
    nop  = '0;
    add  = mk(1,1,0,0,0,1,0,3'b010, 32'd5, 32'd7, 32'd0, 32'h104, 5'd1, 5'd2, 5'd3);
    lw8  = mk(1,1,1,0,1,0,0,3'b010, 32'h1000, 32'd0, 32'd4, 32'h108, 5'd4, 5'd8, 5'd0);
    dep8 = mk(1,1,0,0,0,1,0,3'b010, 32'd11, 32'd12, 32'd0, 32'h10c, 5'd8, 5'd2, 5'd9);
    lw0  = mk(1,1,1,0,1,0,0,3'b010, 32'h2000, 32'd0, 32'd8, 32'h110, 5'd4, 5'd0, 5'd0);
    dep0 = mk(1,1,0,0,0,1,0,3'b110, 32'd21, 32'd22, 32'd0, 32'h114, 5'd0, 5'd3, 5'd10);
    lw9  = mk(1,1,1,0,1,0,0,3'b010, 32'h3000, 32'd0, 32'd12, 32'h118, 5'd5, 5'd9, 5'd0);
    dep9 = mk(1,0,0,0,0,0,1,3'b110, 32'd31, 32'd32, 32'hfffffffc, 32'h11c, 5'd1, 5'd9, 5'd0);
    sw   = mk(1,0,0,1,1,0,0,3'b010, 32'h4000, 32'd99, 32'd16, 32'h120, 5'd6, 5'd7, 5'd0);
    inv  = mk(0,1,1,1,1,1,1,3'b111, 'x, 'x, 'x, 'x, 'x, 'x, 'x);
    lw6  = mk(1,1,1,0,1,0,0,3'b010, 32'h5000, 32'd0, 32'd20, 32'h124, 5'd7, 5'd6, 5'd0);
    dep6 = mk(1,1,0,0,0,1,0,3'b010, 32'd41, 32'd42, 32'd0, 32'h128, 5'd6, 5'd1, 5'd11);
    lw7  = mk(1,1,1,0,1,0,0,3'b010, 32'h6000, 32'd0, 32'd24, 32'h12c, 5'd2, 5'd7, 5'd0);
    dep7 = mk(1,1,0,0,0,1,0,3'b010, 32'd51, 32'd52, 32'd0, 32'h130, 5'd3, 5'd7, 5'd12);

    // Asynchronous reset before any clock edge
    reset_n = 1'b0;
    set_d(nop, 1'b0);
    #2;
    chk("reset.e", 256'(get_e()), 256'(e_t'('0)));
    chk("reset.stallcnt", 256'(ifc.stallcnt), 256'(16'd0));
    chk("reset.stalld", 256'(ifc.stalld), 256'(1'b0));
    @(negedge clk);
    reset_n = 1'b1;

    apply(add,  1'b0, "rtype_add");
    apply(lw8,  1'b0, "lw8");
    apply(dep8, 1'b0, "loaduse_rs8");
    apply(lw0,  1'b0, "lw0");
    apply(dep0, 1'b0, "no_stall_r0");
    apply(lw9,  1'b0, "lw9");
    apply(dep9, 1'b1, "flush_and_stall");
    apply(sw,   1'b1, "flush_sw");
    apply(inv,  1'b0, "invalid_x");
    apply(lw7,  1'b0, "lw7");
    apply(dep7, 1'b0, "loaduse_rt7");
    apply(lw6,  1'b0, "lw6");

    // Reset mid-stall: valide=1, stallcnt=3, stall active combinationally
    set_d(dep6, 1'b0);
    #1;
    chk("pre_reset.stalld", 256'(ifc.stalld), 256'(1'b1));
    chk("pre_reset.stallcnt", 256'(ifc.stallcnt), 256'(16'd3));
    reset_n = 1'b0;
    #1;
    chk("mid_reset.e", 256'(get_e()), 256'(e_t'('0)));
    chk("mid_reset.stallcnt", 256'(ifc.stallcnt), 256'(16'd0));
    chk("mid_reset.stallf", 256'(ifc.stallf), 256'(1'b0));
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_e   = '0;
    model_cnt = 16'd0;
    sb.delete();
    apply(dep6, 1'b0, "after_reset");

    // Random traffic with narrow register ranges to provoke hazards
    for (int i = 0; i < 40; i++) begin
      r = mk(1'($urandom_range(0, 5) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom), $urandom, $urandom,
             $urandom, $urandom, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom));
      apply(r, 1'($urandom_range(0, 7) == 0), "random");
    end

    // Saturation: hold the stall request for more cycles than the counter range
    set_d(nop, 1'b0);
    force dut.lwstall = 1'b1;
    repeat (65540) @(posedge clk);
    #1;
    chk("sat.stallcnt", 256'(ifc.stallcnt), 256'(16'hFFFF));
    chk("sat.valide", 256'(ifc.valide), 256'(1'b0));
    @(negedge clk);
    release dut.lwstall;
    model_e   = '0;
    model_cnt = 16'hFFFF;
    apply(lw8,  1'b0, "sat_lw8");
    apply(dep8, 1'b0, "sat_no_wrap");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have no parameters; all widths fixed (32-bit datapath, 5-bit register specifiers).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 validd  input  1  decode-stage instruction is real, not a bubble.
REQ-005 regwrited, memtoregd, memwrited, alusrcd, regdstd, branchd  input  1 each  decode-stage control bits from main decoder.
REQ-006 alucontrold  input  3  decode-stage ALU control.
REQ-007 rd1d, rd2d, signimmd, pcplus4d  input  32 each  decode-stage operands, sign-extended immediate, PC+4.
REQ-008 rsd, rtd, rdd  input  5 each  decode-stage register specifiers.
REQ-009 flushe  input  1  branch taken in execute; squash the instruction entering E.
REQ-010 regwritee, memtoregee, memwritee, alusrce, regdste, branche  output  1 each  registered E-stage control.
REQ-011 alucontrole  output  3; rd1e, rd2e, signimme, pcplus4e  output  32 each; rse, rte, rde  output  5 each  registered E-stage fields.
REQ-012 valide  output  1  E-stage holds a real instruction.
REQ-013 stallf, stalld  output  1 each  combinational load-use stall requests to fetch and IF/ID register.
REQ-014 stallcnt  output  16  registered count of load-use stall cycles.

Function
REQ-015 lwstall SHALL be asserted combinationally iff valide & memtoregee & validd & rte != 0 & (rte == rsd | rte == rtd).
REQ-016 stallf and stalld SHALL both equal lwstall; no other source drives them.
REQ-017 Each rising edge, when lwstall=0 and flushe=0, the E register SHALL capture every D input; valide <= validd.
REQ-018 When lwstall=1 or flushe=1, the E register SHALL load a bubble: all control outputs, alucontrole, data, specifiers = 0, valide = 0.
REQ-019 flushe and lwstall asserted together SHALL produce a single bubble; stallf/stalld still follow lwstall.
REQ-020 Latency D->E SHALL be exactly one cycle; no internal buffering beyond one register stage.
REQ-021 validd=0 SHALL propagate as a bubble with control outputs forced to 0 regardless of D control inputs.
REQ-022 stallcnt SHALL increment by 1 on each rising edge where lwstall=1, saturating at 16'hFFFF (no wrap).
REQ-023 Outputs SHALL be free of X whenever reset_n has been deasserted at least one cycle, even if D inputs are X while validd=0.

Reset
REQ-024 reset_n=0 SHALL immediately (without clock) clear all E outputs to 0, valide=0, stallcnt=0.
REQ-025 Reset asserted mid-stall SHALL clear state; first cycle after release shows valide=0 and lwstall=0.
REQ-026 Reset release SHALL take effect on the first rising clk edge with reset_n=1.

Verification
REQ-027 R-type add (regwrited=1, regdstd=1, alucontrold=3'b010, rd1d=5, rd2d=7, validd=1), no hazards -> next cycle regwritee=1, regdste=1, rd1e=5, rd2e=7, valide=1, stalld=0.
REQ-028 lw $8 in E (memtoregee=1, rte=8, valide=1) followed by add using rsd=8 -> stallf=stalld=1 that cycle; next cycle E holds bubble (valide=0), stallcnt=1.
REQ-029 lw $0 in E with rsd=0 in D -> no stall; D instruction enters E normally.
REQ-030 flushe=1 with valid sw in D (memwrited=1) -> next cycle memwritee=0, valide=0.
REQ-031 Force 65540 consecutive lwstall cycles -> stallcnt holds 16'hFFFF, no wrap.
REQ-032 Assert reset_n=0 between clock edges while valide=1 and stallcnt=3 -> all outputs 0 immediately, before next edge.
